// File: rtl/mode_counter_if.sv
// mode_counter_if: control inputs, count and status outputs of mode_counter
interface mode_counter_if #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 4
);
  logic                      ENABLE_IN;
  logic                      DIR_IN;
  logic                      MODE_IN;
  logic                      CLEAR_IN;
  logic                      LOAD_IN;
  logic [COUNTER_WIDTH-1:0]  LOAD_VALUE;
  logic                      MAX_WR;
  logic [COUNTER_WIDTH-1:0]  MAX_IN;
  logic [PRESCALE_WIDTH-1:0] PRESCALE_IN;
  logic [COUNTER_WIDTH-1:0]  COUNT;
  logic                      TRIG_OUT;
  logic                      DONE_OUT;
  modport master (
    output ENABLE_IN, DIR_IN, MODE_IN, CLEAR_IN, LOAD_IN, LOAD_VALUE, MAX_WR, MAX_IN, PRESCALE_IN,
    input  COUNT, TRIG_OUT, DONE_OUT
  );
  modport slave (
    input  ENABLE_IN, DIR_IN, MODE_IN, CLEAR_IN, LOAD_IN, LOAD_VALUE, MAX_WR, MAX_IN, PRESCALE_IN,
    output COUNT, TRIG_OUT, DONE_OUT
  );
endinterface

// File: rtl/mode_counter.sv
// mode_counter: prescaled up/down counter with programmable terminal value, periodic or one-shot
module mode_counter #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int COUNTER_MAX    = 192,
  parameter int PRESCALE_WIDTH = 4
) (
  input logic           CLK,
  input logic           Reset,
  mode_counter_if.slave bus
);
  typedef enum logic {RUN, DONE} state_t;
  state_t                    state;
  logic [COUNTER_WIDTH-1:0]  count;
  logic [COUNTER_WIDTH-1:0]  max_q;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic                      trig;
  logic                      adv;
  logic                      tick;
  logic                      term;
  // Tick decode: >= on the prescaler tolerates PRESCALE_IN lowered under the running count,
  // >= on MAX stops a load above MAX from running away
  always_comb begin
    adv  = state == RUN && bus.ENABLE_IN;
    tick = adv && pre >= bus.PRESCALE_IN;
    term = bus.DIR_IN ? count == '0 : count >= max_q;
  end
  // State, count, prescaler and MAX register; CLEAR/LOAD outrank the tick and kill its pulse
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= RUN;
      count <= '0;
      max_q <= COUNTER_WIDTH'(COUNTER_MAX);
      pre   <= '0;
      trig  <= 1'b0;
    end else begin
      trig <= 1'b0;
      if (bus.MAX_WR) max_q <= bus.MAX_IN;
      if (bus.CLEAR_IN || bus.LOAD_IN) begin
        state <= RUN;
        count <= bus.CLEAR_IN ? '0 : bus.LOAD_VALUE;
        pre   <= '0;
      end else if (adv) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick && term) begin
          trig  <= 1'b1;
          state <= bus.MODE_IN ? DONE : RUN;
          count <= bus.MODE_IN ? (bus.DIR_IN ? '0 : count) : (bus.DIR_IN ? max_q : '0);
        end else if (tick) begin
          count <= bus.DIR_IN ? count - 1'b1 : count + 1'b1;
        end
      end
    end
  end
  assign bus.COUNT    = count;
  assign bus.TRIG_OUT = trig;
  assign bus.DONE_OUT = state == DONE;
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed vector table plus hand-written multi-cycle sequences for mode_counter
module tb_mode_counter;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  mode_counter_if #(.COUNTER_WIDTH(8), .PRESCALE_WIDTH(4)) bus();
  mode_counter #(.COUNTER_WIDTH(8), .COUNTER_MAX(192), .PRESCALE_WIDTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus)
  );
  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       mw;
    logic [7:0] mi;
    logic       en;
    logic       dir;
    logic       mode;
    logic [3:0] pre;
    logic [7:0] cnt;
    logic       trig;
    logic       done;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(logic clr, logic ld, logic [7:0] lv, logic mw, logic [7:0] mi,
                       logic en, logic dir, logic mode, logic [3:0] pre);
    bus.CLEAR_IN = clr; bus.LOAD_IN = ld; bus.LOAD_VALUE = lv;
    bus.MAX_WR = mw; bus.MAX_IN = mi; bus.ENABLE_IN = en;
    bus.DIR_IN = dir; bus.MODE_IN = mode; bus.PRESCALE_IN = pre;
  endtask
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask
  task automatic add(logic clr, logic ld, logic [7:0] lv, logic mw, logic [7:0] mi, logic en,
                     logic dir, logic mode, logic [3:0] pre, logic [7:0] cnt, logic trig, logic done);
    vec_t v;
    v = '{clr, ld, lv, mw, mi, en, dir, mode, pre, cnt, trig, done};
    vecs.push_back(v);
  endtask
  task automatic chk_out(string tag, logic [7:0] cnt, logic trig, logic done);
    chk({tag, " count"}, 32'(bus.COUNT), 32'(cnt));
    chk({tag, " trig"}, 32'(bus.TRIG_OUT), 32'(trig));
    chk({tag, " done"}, 32'(bus.DONE_OUT), 32'(done));
  endtask
  initial begin
    int e;
    //  clr ld lv   mw mi  en dir mode pre  cnt trig done
    add(1, 0, 0,   0, 0,  0, 0, 0, 0,     0, 0, 0);
    add(0, 0, 0,   1, 5,  1, 0, 0, 0,     1, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     2, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     3, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     4, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     5, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0,   0, 0,  0, 0, 0, 0,     0, 0, 0);
    add(0, 1, 200, 0, 0,  0, 0, 0, 0,   200, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0,   0, 0,  1, 1, 0, 0,     5, 1, 0);
    add(0, 0, 0,   0, 0,  1, 1, 0, 0,     4, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     5, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 1, 0);
    add(0, 1, 3,   0, 0,  1, 1, 1, 0,     3, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     2, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     1, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     0, 1, 1);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     0, 0, 1);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 0, 1);
    add(0, 1, 2,   0, 0,  1, 1, 1, 0,     2, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     1, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,     0, 0, 0);
    add(1, 1, 9,   1, 10, 1, 1, 1, 0,     0, 0, 0);
    add(0, 1, 9,   0, 0,  0, 0, 0, 0,     9, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,    10, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 1, 0);
    add(0, 1, 10,  0, 0,  1, 0, 1, 0,    10, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 1, 0,    10, 1, 1);
    add(0, 0, 0,   0, 0,  1, 1, 1, 0,    10, 0, 1);
    add(1, 0, 0,   0, 0,  1, 0, 0, 0,     0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 2,     0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 2,     0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 2,     1, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     2, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 3,     2, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 3,     2, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 1,     3, 0, 0);
    add(0, 0, 0,   1, 0,  1, 0, 0, 0,     4, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0,   0, 0,  1, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0,   0, 0,  0, 0, 0, 0,     0, 0, 0);
    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk_out("reset", 0, 0, 0);
    // Defaults, up, periodic: frame of 193 cycles
    Reset = 1'b0;
    bus.ENABLE_IN = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      cyc();
      chk($sformatf("dflt c%0d count", i), 32'(bus.COUNT), 32'(i % 193));
      chk($sformatf("dflt c%0d trig", i), 32'(bus.TRIG_OUT), 32'(i % 193 == 0));
    end
    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].mw, vecs[i].mi,
            vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].pre);
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].trig, vecs[i].done);
    end
    // MAX=5, prescale 2, with a 4-cycle pause mid-run
    drive(1, 0, 0, 1, 5, 0, 0, 0, 2);
    cyc();
    chk_out("pre clr", 0, 0, 0);
    e = 0;
    for (int i = 1; i <= 60; i++) begin
      bus.CLEAR_IN = 1'b0;
      bus.MAX_WR = 1'b0;
      bus.ENABLE_IN = !(i >= 25 && i <= 28);
      if (bus.ENABLE_IN) e++;
      cyc();
      chk($sformatf("pre c%0d count", i), 32'(bus.COUNT), 32'((e / 3) % 6));
      chk($sformatf("pre c%0d trig", i), 32'(bus.TRIG_OUT), 32'(i < 25 || i > 28 ? e % 18 == 0 : 0));
    end
    // Reset mid-count with COUNT=77, MAX=9; a glitch between edges is ignored
    drive(0, 1, 77, 1, 9, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    cyc();
    chk_out("glitch", 77, 0, 0);
    bus.ENABLE_IN = 1'b1;
    Reset = 1'b1;
    cyc();
    chk_out("rst mid", 0, 0, 0);
    Reset = 1'b0;
    drive(0, 1, 191, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_out("rst ld", 191, 0, 0);
    bus.LOAD_IN = 1'b0;
    bus.ENABLE_IN = 1'b1;
    cyc();
    chk_out("rst max a", 192, 0, 0);
    cyc();
    chk_out("rst max b", 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
